// File: rtl/led_group_ctrl_if.sv
// Bus between the game state machine and the LED group selector.
// Game logic drives state, button and table writes; the selector drives the LEDs and capture.
interface led_group_ctrl_if #(
  parameter int NUM_LED = 8,
  parameter int GRP_W   = 3
);
  logic [2:0]         state;
  logic               btn_down;
  logic               pat_we;
  logic [GRP_W-1:0]   pat_addr;
  logic [NUM_LED-1:0] pat_data;
  logic [NUM_LED-1:0] LED;
  logic [GRP_W-1:0]   selected_group;
  logic               sel_valid;

  modport master (
    output state, btn_down, pat_we, pat_addr, pat_data,
    input  LED, selected_group, sel_valid
  );

  modport slave (
    input  state, btn_down, pat_we, pat_addr, pat_data,
    output LED, selected_group, sel_valid
  );
endinterface

// File: rtl/led_group_ctrl.sv
// Pinball LED group selector: cycles a pattern table in START, captures a group on a
// button press, shows the capture blinking in GET and blinks everything in OVER.
module led_group_ctrl #(
  parameter int NUM_LED   = 8,
  parameter int NUM_GRP   = 8,
  parameter int GRP_W     = 3,
  parameter int FLASH_DIV = 25_000_000,
  parameter int DIV_W     = 25
) (
  input  logic              clk,
  input  logic              reset,
  led_group_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_GET   = 3'd3,
    ST_OVER  = 3'd4
  } game_state_e;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(FLASH_DIV - 1);
  localparam logic [GRP_W-1:0] FLASH_LAST = GRP_W'(NUM_GRP - 1);
  localparam logic [GRP_W:0]   GRP_LIMIT  = (GRP_W + 1)'(NUM_GRP);

  logic [DIV_W-1:0]   divCnt_q,    divCnt_d;
  logic [GRP_W-1:0]   flashCnt_q,  flashCnt_d;
  logic               phase_q,     phase_d;
  logic               btnPrev_q;
  logic [2:0]         prevState_q;
  logic [GRP_W-1:0]   capGrp_q,    capGrp_d;
  logic [NUM_LED-1:0] capPat_q,    capPat_d;
  logic               selValid_q,  selValid_d;
  logic [NUM_LED-1:0] led_q,       led_d;
  logic [NUM_LED-1:0] pat_q [NUM_GRP];

  logic run;
  logic blink;
  logic entry;
  logic tick;
  logic press;
  logic patWrite;

  // Timing events: a fresh entry into GET/OVER restarts the divider so the
  // first blink toggle lands a full FLASH_DIV cycles after entry.
  always_comb begin
    run      = (bus.state == ST_START) || (bus.state == ST_GET) || (bus.state == ST_OVER);
    blink    = (bus.state == ST_GET) || (bus.state == ST_OVER);
    entry    = blink && (bus.state != prevState_q);
    tick     = run && !entry && (divCnt_q == DIV_LAST);
    press    = bus.btn_down && !btnPrev_q;
    patWrite = bus.pat_we && ({1'b0, bus.pat_addr} < GRP_LIMIT);
  end

  always_comb begin
    divCnt_d = '0;
    if (entry) begin
      divCnt_d = DIV_W'(1);
    end else if (run && !tick) begin
      divCnt_d = divCnt_q + 1'b1;
    end

    phase_d = 1'b0;
    if (blink && !entry) begin
      phase_d = phase_q ^ tick;
    end

    flashCnt_d = flashCnt_q;
    if ((bus.state == ST_RESET) || (bus.state == ST_WAIT)) begin
      flashCnt_d = '0;
    end else if ((bus.state == ST_START) && tick) begin
      flashCnt_d = (flashCnt_q == FLASH_LAST) ? '0 : flashCnt_q + 1'b1;
    end
  end

  // Capture uses the pre-increment flash index and the stored table entry.
  always_comb begin
    capGrp_d   = capGrp_q;
    capPat_d   = capPat_q;
    selValid_d = selValid_q;
    if ((bus.state == ST_RESET) || (bus.state == ST_WAIT)) begin
      capGrp_d   = '0;
      capPat_d   = '0;
      selValid_d = 1'b0;
    end else if ((bus.state == ST_START) && press) begin
      capGrp_d   = flashCnt_q;
      capPat_d   = pat_q[flashCnt_q];
      selValid_d = 1'b1;
    end
  end

  // A write to the displayed entry is forwarded so it shows on the very next edge.
  always_comb begin
    led_d = '0;
    case (bus.state)
      ST_WAIT:  led_d = '1;
      ST_START: led_d = (bus.pat_we && (bus.pat_addr == flashCnt_q)) ? bus.pat_data
                                                                     : pat_q[flashCnt_q];
      ST_GET:   led_d = phase_q ? '0 : capPat_q;
      ST_OVER:  led_d = phase_q ? '0 : '1;
      default:  led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt_q    <= '0;
      flashCnt_q  <= '0;
      phase_q     <= 1'b0;
      btnPrev_q   <= 1'b0;
      prevState_q <= '0;
      capGrp_q    <= '0;
      capPat_q    <= '0;
      selValid_q  <= 1'b0;
      led_q       <= '0;
      for (int i = 0; i < NUM_GRP; i++) begin
        pat_q[i] <= NUM_LED'(1) << (i % NUM_LED);
      end
    end else begin
      divCnt_q    <= divCnt_d;
      flashCnt_q  <= flashCnt_d;
      phase_q     <= phase_d;
      btnPrev_q   <= bus.btn_down;
      prevState_q <= bus.state;
      capGrp_q    <= capGrp_d;
      capPat_q    <= capPat_d;
      selValid_q  <= selValid_d;
      led_q       <= led_d;
      if (patWrite) begin
        pat_q[bus.pat_addr] <= bus.pat_data;
      end
    end
  end

  assign bus.LED            = led_q;
  assign bus.selected_group = capGrp_q;
  assign bus.sel_valid      = selValid_q;

endmodule
